// File: rtl/cmul_pkg.sv
// ============================================================================
// Module      : cmul_pkg
// Description : Shared types and constants for the sequential complex
//               multiplier (state encoding, default operand width).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package cmul_pkg;

  // Default operand width. The datapath sub-modules are sized for 16 bits.
  localparam int CMUL_W = 16;

  // One state per multiplier pass, plus the result and handshake states.
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    AC   = 3'd1,
    BD   = 3'd2,
    AD   = 3'd3,
    BC   = 3'd4,
    SUM  = 3'd5,
    OUT  = 3'd6
  } state_t;

endpackage : cmul_pkg

`default_nettype wire

// File: rtl/cla32.sv
// ============================================================================
// Module      : cla32
// Description : 32-bit adder built from eight 4-bit carry-lookahead groups
//               with rippled group carries.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cla32 (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        cin,
  output logic [31:0] s,
  output logic        cout
);

  logic [31:0] g;
  logic [31:0] p;
  logic [8:0]  gc;

  assign g     = a & b;
  assign p     = a ^ b;
  assign gc[0] = cin;
  assign cout  = gc[8];

  // Each group resolves its internal carries in parallel from its own
  // generate/propagate terms and the incoming group carry.
  generate
    for (genvar k = 0; k < 8; k++) begin : g_grp
      logic [3:0] gg;
      logic [3:0] pp;
      logic       c0;
      logic       c1;
      logic       c2;
      logic       c3;

      assign gg = g[4*k +: 4];
      assign pp = p[4*k +: 4];
      assign c0 = gc[k];
      assign c1 = gg[0] | (pp[0] & c0);
      assign c2 = gg[1] | (pp[1] & gg[0]) | (pp[1] & pp[0] & c0);
      assign c3 = gg[2] | (pp[2] & gg[1]) | (pp[2] & pp[1] & gg[0])
                | (pp[2] & pp[1] & pp[0] & c0);
      assign gc[k + 1] = gg[3] | (pp[3] & gg[2]) | (pp[3] & pp[2] & gg[1])
                       | (pp[3] & pp[2] & pp[1] & gg[0])
                       | (pp[3] & pp[2] & pp[1] & pp[0] & c0);
      assign s[4*k +: 4] = pp ^ {c3, c2, c1, c0};
    end
  endgenerate

endmodule : cla32

`default_nettype wire

// File: rtl/fs32.sv
// ============================================================================
// Module      : fs32
// Description : 32-bit ripple full subtractor, d = a - b - bin, with
//               borrow-out.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fs32 (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        bin,
  output logic [31:0] d,
  output logic        bout
);

  logic [32:0] borrow;

  assign borrow[0] = bin;
  assign bout      = borrow[32];

  // One full-subtractor cell per bit; borrow ripples from LSB to MSB.
  generate
    for (genvar i = 0; i < 32; i++) begin : g_bit
      assign d[i]          = a[i] ^ b[i] ^ borrow[i];
      assign borrow[i + 1] = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & borrow[i]);
    end
  endgenerate

endmodule : fs32

`default_nettype wire

// File: rtl/vedic16.sv
// ============================================================================
// Module      : vedic16
// Description : 16x16 unsigned multiplier, vertical/crosswise (vedic)
//               composition of four 8x8 partial products.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module vedic16 (
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [31:0] p
);

  logic [15:0] pp_ll;
  logic [15:0] pp_lh;
  logic [15:0] pp_hl;
  logic [15:0] pp_hh;
  logic [16:0] cross_sum;

  // Vertical (ll, hh) and crosswise (lh, hl) 8x8 products, then merge the
  // crosswise pair at bit 8 on top of the concatenated vertical products.
  always_comb begin
    pp_ll     = a[7:0]  * b[7:0];
    pp_lh     = a[7:0]  * b[15:8];
    pp_hl     = a[15:8] * b[7:0];
    pp_hh     = a[15:8] * b[15:8];
    cross_sum = {1'b0, pp_lh} + {1'b0, pp_hl};
    p         = {pp_hh, pp_ll} + {7'd0, cross_sum, 8'd0};
  end

endmodule : vedic16

`default_nettype wire

// File: rtl/cmul_seq.sv
// ============================================================================
// Module      : cmul_seq
// Description : Sequential complex multiplier. One shared 16x16 multiplier
//               forms the four cross products over four cycles; the real
//               part goes through fs32, the imaginary part through cla32.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cmul_seq
  import cmul_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [CMUL_W-1:0]   ar,
  input  logic [CMUL_W-1:0]   ai,
  input  logic [CMUL_W-1:0]   br,
  input  logic [CMUL_W-1:0]   bi,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [2*CMUL_W-1:0] re,
  output logic                re_neg,
  output logic [2*CMUL_W:0]   im
);

  state_t state;
  state_t state_n;

  logic [CMUL_W-1:0]   op_ar;
  logic [CMUL_W-1:0]   op_ai;
  logic [CMUL_W-1:0]   op_br;
  logic [CMUL_W-1:0]   op_bi;
  logic [2*CMUL_W-1:0] p_ac;
  logic [2*CMUL_W-1:0] p_bd;
  logic [2*CMUL_W-1:0] p_ad;
  logic [2*CMUL_W-1:0] p_bc;

  logic [CMUL_W-1:0]   mul_a;
  logic [CMUL_W-1:0]   mul_b;
  logic [2*CMUL_W-1:0] mul_p;
  logic [2*CMUL_W-1:0] sub_d;
  logic                sub_bout;
  logic [2*CMUL_W-1:0] add_s;
  logic                add_c;

  assign in_ready = (state == IDLE);

  // State register; reset aborts any transaction in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  // Next-state: fixed walk through the four multiply passes, then hold in
  // OUT until the consumer takes the result.
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (in_valid) state_n = AC;
      AC:      state_n = BD;
      BD:      state_n = AD;
      AD:      state_n = BC;
      BC:      state_n = SUM;
      SUM:     state_n = OUT;
      OUT:     if (out_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Operand mux for the shared multiplier, selected by the current pass.
  always_comb begin
    mul_a = '0;
    mul_b = '0;
    case (state)
      AC:      begin mul_a = op_ar; mul_b = op_br; end
      BD:      begin mul_a = op_ai; mul_b = op_bi; end
      AD:      begin mul_a = op_ar; mul_b = op_bi; end
      BC:      begin mul_a = op_ai; mul_b = op_br; end
      default: begin mul_a = '0;    mul_b = '0;    end
    endcase
  end

  vedic16 u_mul (
    .a (mul_a),
    .b (mul_b),
    .p (mul_p)
  );

  fs32 u_sub (
    .a    (p_ac),
    .b    (p_bd),
    .bin  (1'b0),
    .d    (sub_d),
    .bout (sub_bout)
  );

  cla32 u_add (
    .a    (p_ad),
    .b    (p_bc),
    .cin  (1'b0),
    .s    (add_s),
    .cout (add_c)
  );

  // Operand capture, per-pass product capture and result/valid registers.
  // Results are only written in SUM, so they stay frozen through OUT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_ar     <= '0;
      op_ai     <= '0;
      op_br     <= '0;
      op_bi     <= '0;
      p_ac      <= '0;
      p_bd      <= '0;
      p_ad      <= '0;
      p_bc      <= '0;
      re        <= '0;
      re_neg    <= 1'b0;
      im        <= '0;
      out_valid <= 1'b0;
    end else begin
      if (state == IDLE && in_valid) begin
        op_ar <= ar;
        op_ai <= ai;
        op_br <= br;
        op_bi <= bi;
      end
      if (state == AC) p_ac <= mul_p;
      if (state == BD) p_bd <= mul_p;
      if (state == AD) p_ad <= mul_p;
      if (state == BC) p_bc <= mul_p;
      if (state == SUM) begin
        re        <= sub_d;
        re_neg    <= sub_bout;
        im        <= {add_c, add_s};
        out_valid <= 1'b1;
      end else if (state == OUT && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule : cmul_seq

`default_nettype wire

// File: tb/tb_cmul_seq.sv
// ============================================================================
// Module      : tb_cmul_seq
// Description : Self-checking bench for cmul_seq: table of directed complex
//               products plus backpressure, mid-transaction reset and
//               back-to-back sequences.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cmul_seq;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] ar;
  logic [15:0] ai;
  logic [15:0] br;
  logic [15:0] bi;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] re;
  logic        re_neg;
  logic [32:0] im;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  typedef struct {
    logic [15:0] ar;
    logic [15:0] ai;
    logic [15:0] br;
    logic [15:0] bi;
    logic [31:0] re;
    logic        re_neg;
    logic [32:0] im;
  } vec_t;

  vec_t vecs[6];

  cmul_seq dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .ar        (ar),
    .ai        (ai),
    .br        (br),
    .bi        (bi),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .re        (re),
    .re_neg    (re_neg),
    .im        (im)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic set_ops(input vec_t v);
    ar = v.ar;
    ai = v.ai;
    br = v.br;
    bi = v.bi;
  endtask

  // Full transaction; starts and ends on a negedge with the DUT idle.
  task automatic run_txn(input vec_t v, input string tag);
    int k;
    set_ops(v);
    in_valid = 1'b1;
    check({tag, "_in_ready_idle"}, 64'(in_ready), 64'd1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    check({tag, "_in_ready_busy"}, 64'(in_ready), 64'd0);
    k = 0;
    while (!out_valid && k < 20) begin
      @(posedge clk);
      @(negedge clk);
      k++;
    end
    check({tag, "_latency"}, 64'(k), 64'd5);
    check({tag, "_re"}, 64'(re), 64'(v.re));
    check({tag, "_re_neg"}, 64'(re_neg), 64'(v.re_neg));
    check({tag, "_im"}, 64'(im), 64'(v.im));
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, "_out_valid_cleared"}, 64'(out_valid), 64'd0);
    check({tag, "_in_ready_back"}, 64'(in_ready), 64'd1);
  endtask

  initial begin
    int k;
    int acc[4];
    logic seen;

    vecs[0] = '{16'd3, 16'd4, 16'd5, 16'd6, 32'hFFFF_FFF7, 1'b1, 33'd38};
    vecs[1] = '{16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 32'h0, 1'b0, 33'h1_FFFC_0002};
    vecs[2] = '{16'd2, 16'd2, 16'd3, 16'd3, 32'h0, 1'b0, 33'd12};
    vecs[3] = '{16'd0, 16'd0, 16'd0, 16'd0, 32'h0, 1'b0, 33'd0};
    vecs[4] = '{16'h1234, 16'd0, 16'h0010, 16'd0, 32'h0001_2340, 1'b0, 33'd0};
    vecs[5] = '{16'd1, 16'hFFFF, 16'd1, 16'd1, 32'hFFFF_0002, 1'b1, 33'h1_0000};

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    ar = '0; ai = '0; br = '0; bi = '0;
    @(negedge clk);
    @(negedge clk);
    check("reset_in_ready", 64'(in_ready), 64'd1);
    check("reset_out_valid", 64'(out_valid), 64'd0);
    check("reset_re", 64'(re), 64'd0);
    check("reset_re_neg", 64'(re_neg), 64'd0);
    check("reset_im", 64'(im), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Table of directed vectors.
    for (int i = 0; i < 6; i++) begin
      run_txn(vecs[i], $sformatf("vec%0d", i));
    end

    // out_ready while nothing is pending must not disturb idle.
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check("stray_ready_out_valid", 64'(out_valid), 64'd0);
    check("stray_ready_in_ready", 64'(in_ready), 64'd1);

    // Backpressure: hold the result three cycles while new operands knock.
    set_ops(vecs[0]);
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    k = 0;
    while (!out_valid && k < 20) begin
      @(negedge clk);
      k++;
    end
    check("bp_latency", 64'(k), 64'd5);
    for (int c = 0; c < 3; c++) begin
      ar = 16'd9; ai = 16'd9; br = 16'd9; bi = 16'd9;
      in_valid = (c == 1);
      @(posedge clk);
      @(negedge clk);
      check("bp_out_valid_held", 64'(out_valid), 64'd1);
      check("bp_re_stable", 64'(re), 64'hFFFF_FFF7);
      check("bp_re_neg_stable", 64'(re_neg), 64'd1);
      check("bp_im_stable", 64'(im), 64'd38);
      check("bp_in_ready_low", 64'(in_ready), 64'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check("bp_accept_out_valid", 64'(out_valid), 64'd0);
    check("bp_accept_in_ready", 64'(in_ready), 64'd1);
    seen = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    check("bp_knock_ignored", 64'(seen), 64'd0);

    // Reset asserted while the BD pass is active.
    set_ops(vecs[1]);
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rst_bd_out_valid", 64'(out_valid), 64'd0);
    check("rst_bd_in_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_bd_re", 64'(re), 64'd0);
    check("rst_bd_re_neg", 64'(re_neg), 64'd0);
    check("rst_bd_im", 64'(im), 64'd0);
    check("rst_bd_in_ready_after", 64'(in_ready), 64'd1);
    run_txn(vecs[0], "post_rst");

    // Back-to-back with both handshakes tied high.
    in_valid  = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      set_ops(vecs[i + 1]);
      k = 0;
      while (!in_ready && k < 20) begin
        @(negedge clk);
        k++;
      end
      check($sformatf("b2b%0d_in_ready_wait", i), 64'(k < 20), 64'd1);
      @(posedge clk);
      @(negedge clk);
      acc[i] = cyc;
      k = 0;
      while (!out_valid && k < 20) begin
        @(negedge clk);
        k++;
      end
      check($sformatf("b2b%0d_latency", i), 64'(k), 64'd5);
      check($sformatf("b2b%0d_re", i), 64'(re), 64'(vecs[i + 1].re));
      check($sformatf("b2b%0d_re_neg", i), 64'(re_neg), 64'(vecs[i + 1].re_neg));
      check($sformatf("b2b%0d_im", i), 64'(im), 64'(vecs[i + 1].im));
      if (i > 0) begin
        check($sformatf("b2b%0d_period", i), 64'(acc[i] - acc[i - 1]), 64'd7);
      end
    end
    in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check("b2b_end_out_valid", 64'(out_valid), 64'd0);
    check("b2b_end_in_ready", 64'(in_ready), 64'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_cmul_seq

`default_nettype wire
